// File: rtl/swu_pkg.sv
// Shared constants, FSM state type and sizing helpers for the ECG sliding-window unit.
package swu_pkg;

   localparam int unsigned ROM_W     = 32;
   localparam int unsigned ECG_WORDS = 29;
   localparam int unsigned WIN       = 7;
   localparam int unsigned STRIDE    = 2;

   typedef enum logic [2:0] {
      StIdle,
      StRd0,
      StRd1,
      StWt,
      StRun,
      StRf,
      StRw,
      StDone
   } swu_state_e;

   function automatic int unsigned num_win(input int unsigned rom_w, input int unsigned words,
                                           input int unsigned win, input int unsigned stride);
      return (words * rom_w - win) / stride + 1;
   endfunction

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/swu_seq_ctrl_if.sv
// ROM read port and window stream bundled between the sequencer, the ECG ROM and the PE array.
interface swu_seq_ctrl_if #(
   parameter int unsigned ROM_W     = swu_pkg::ROM_W,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned NUM_WORDS = swu_pkg::ECG_WORDS,
   parameter int unsigned WIN       = swu_pkg::WIN,
   parameter int unsigned STRIDE    = swu_pkg::STRIDE
);
   localparam int unsigned IDX_W =
      swu_pkg::idx_w(swu_pkg::num_win(ROM_W, NUM_WORDS, WIN, STRIDE));

   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [ROM_W-1:0]  rom_data;
   logic [WIN-1:0]    slide_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic [IDX_W-1:0]  win_idx;

   modport master (
      output rom_en, rom_addr, slide_data, out_valid, out_last, win_idx,
      input  rom_data, out_ready
   );

   modport slave (
      input  rom_en, rom_addr, slide_data, out_valid, out_last, win_idx,
      output rom_data, out_ready
   );

endinterface

// File: rtl/swu_win_sel.sv
// Window extractor: picks WIN bits starting ptr bits below the MSB of {buf_hi, buf_lo}.
module swu_win_sel #(
   parameter int unsigned ROM_W = 32,
   parameter int unsigned WIN   = 7,
   parameter int unsigned PTR_W = $clog2(ROM_W)
) (
   input  logic [ROM_W-1:0] buf_hi,
   input  logic [ROM_W-1:0] buf_lo,
   input  logic [PTR_W-1:0] ptr,
   output logic [WIN-1:0]   slide_data
);

   logic [2*ROM_W-1:0] shifted;

   always_comb begin
      shifted    = {buf_hi, buf_lo} << ptr;
      slide_data = shifted[2*ROM_W-1 -: WIN];
   end

endmodule

// File: rtl/swu_seq_ctrl.sv
// ECG sliding-window sequencer: streams ROM words through a two-word buffer and emits
// every WIN-bit window at a STRIDE-bit step over a valid/ready handshake.
module swu_seq_ctrl #(
   parameter int unsigned ROM_W     = swu_pkg::ROM_W,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned NUM_WORDS = swu_pkg::ECG_WORDS,
   parameter int unsigned WIN       = swu_pkg::WIN,
   parameter int unsigned STRIDE    = swu_pkg::STRIDE
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   output logic           busy,
   output logic           done,
   swu_seq_ctrl_if.master bus
);
   import swu_pkg::*;

   localparam int unsigned NUM_WIN = num_win(ROM_W, NUM_WORDS, WIN, STRIDE);
   localparam int unsigned IDX_W   = idx_w(NUM_WIN);
   localparam int unsigned PTR_W   = $clog2(ROM_W);

   localparam logic [PTR_W:0]   ROM_W_P   = (PTR_W+1)'(ROM_W);
   localparam logic [PTR_W:0]   STRIDE_P  = (PTR_W+1)'(STRIDE);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WIN - 1);
   localparam logic [ADDR_W:0]  LAST_WORD = (ADDR_W+1)'(NUM_WORDS - 1);

   swu_state_e        state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [ROM_W-1:0]  buf_hi_q, buf_hi_d;
   logic [ROM_W-1:0]  buf_lo_q, buf_lo_d;
   logic [ADDR_W-1:0] word_q, word_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [PTR_W:0]    ptr_nxt;
   logic [PTR_W:0]    ptr_wrap;

   swu_win_sel #(
      .ROM_W (ROM_W),
      .WIN   (WIN),
      .PTR_W (PTR_W)
   ) u_win_sel (
      .buf_hi     (buf_hi_q),
      .buf_lo     (buf_lo_q),
      .ptr        (ptr_q),
      .slide_data (bus.slide_data)
   );

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      buf_hi_d      = buf_hi_q;
      buf_lo_d      = buf_lo_q;
      word_d        = word_q;
      addr_d        = addr_q;
      idx_d         = idx_q;
      bus.rom_en    = 1'b0;
      bus.out_valid = 1'b0;
      done          = 1'b0;
      ptr_nxt       = {1'b0, ptr_q} + STRIDE_P;
      ptr_wrap      = ptr_nxt - ROM_W_P;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRd0;
               ptr_d   = '0;
               idx_d   = '0;
               word_d  = '0;
            end
         end
         StRd0: begin
            bus.rom_en = 1'b1;
            addr_d     = '0;
            state_d    = StRd1;
         end
         StRd1: begin
            bus.rom_en = 1'b1;
            addr_d     = ADDR_W'(1);
            buf_hi_d   = bus.rom_data;
            state_d    = StWt;
         end
         StWt: begin
            buf_lo_d = bus.rom_data;
            state_d  = StRun;
         end
         StRun: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = StDone;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  if (ptr_nxt < ROM_W_P) begin
                     ptr_d = ptr_nxt[PTR_W-1:0];
                  end else begin
                     // Window crossed into buf_lo: shift words up, refill only if one remains.
                     buf_hi_d = buf_lo_q;
                     ptr_d    = ptr_wrap[PTR_W-1:0];
                     word_d   = word_q + ADDR_W'(1);
                     if ({1'b0, word_q} + (ADDR_W+1)'(2) <= LAST_WORD) begin
                        state_d = StRf;
                     end else begin
                        buf_lo_d = '0;
                     end
                  end
               end
            end
         end
         StRf: begin
            bus.rom_en = 1'b1;
            addr_d     = word_q + ADDR_W'(1);
            state_d    = StRw;
         end
         StRw: begin
            buf_lo_d = bus.rom_data;
            state_d  = StRun;
         end
         StDone: begin
            done    = 1'b1;
            ptr_d   = '0;
            idx_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      bus.rom_addr = addr_d;
      bus.win_idx  = idx_q;
      bus.out_last = (state_q == StRun) && (idx_q == LAST_IDX);
      busy         = (state_q != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         buf_hi_q <= '0;
         buf_lo_q <= '0;
         word_q   <= '0;
         addr_q   <= '0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         buf_hi_q <= buf_hi_d;
         buf_lo_q <= buf_lo_d;
         word_q   <= word_d;
         addr_q   <= addr_d;
         idx_q    <= idx_d;
      end
   end

endmodule

// File: tb/tb_swu_seq_ctrl.sv
// Randomized bench for swu_seq_ctrl: default record and a short two-word record, both
// compared against a bit-stream model of the windows.
module tb_swu_seq_ctrl;

   localparam int unsigned A_NWIN = 461;
   localparam int unsigned B_NWIN = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   logic busy_a, done_a, busy_b, done_b;
   logic rand_ready = 1'b0;

   logic [31:0] rom_a [32];
   logic [31:0] rom_b [32];
   logic [4:0]  max_addr_a = '0;
   logic [4:0]  max_addr_b = '0;

   int n_checks = 0;
   int n_fail   = 0;

   swu_seq_ctrl_if bus_a ();
   swu_seq_ctrl_if #(.NUM_WORDS(2), .STRIDE(3)) bus_b ();

   swu_seq_ctrl u_dut_a (
      .clk   (clk),
      .rst   (rst),
      .start (start_a),
      .busy  (busy_a),
      .done  (done_a),
      .bus   (bus_a)
   );

   swu_seq_ctrl #(
      .NUM_WORDS (2),
      .STRIDE    (3)
   ) u_dut_b (
      .clk   (clk),
      .rst   (rst),
      .start (start_b),
      .busy  (busy_b),
      .done  (done_b),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   // ROM models with one-cycle registered read
   always @(posedge clk) begin
      if (bus_a.rom_en) begin
         bus_a.rom_data <= rom_a[bus_a.rom_addr];
         if (bus_a.rom_addr > max_addr_a) max_addr_a <= bus_a.rom_addr;
      end
      if (bus_b.rom_en) begin
         bus_b.rom_data <= rom_b[bus_b.rom_addr];
         if (bus_b.rom_addr > max_addr_b) max_addr_b <= bus_b.rom_addr;
      end
   end

   always @(posedge clk) begin
      #1;
      bus_a.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Window k = stream bits k*stride .. k*stride+6, stream = words concatenated MSB first
   function automatic logic [6:0] model_win(input bit use_b, input int k);
      int unsigned stride = use_b ? 3 : 2;
      int unsigned nbits  = use_b ? 64 : 29 * 32;
      logic [6:0]  w;
      for (int b = 0; b < 7; b++) begin
         int unsigned j = k * stride + b;
         logic bv;
         if (j >= nbits) bv = 1'b0;
         else if (use_b) bv = rom_b[j / 32][31 - (j % 32)];
         else bv = rom_a[j / 32][31 - (j % 32)];
         w[6 - b] = bv;
      end
      return w;
   endfunction

   // Stream monitor for the default-size record
   int   cyc = 0;
   int   exp_k_a = 0;
   int   hs_a = 0;
   int   last_hs_cyc_a = -10;
   bit   stall_a = 1'b0;
   bit   done_seen_a = 1'b0;
   logic [6:0] stall_data_a;
   logic [8:0] stall_idx_a;
   logic       stall_last_a;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         exp_k_a     = 0;
         stall_a     = 1'b0;
         done_seen_a = 1'b0;
      end else begin
         if (done_seen_a) check_eq("busy_after_done", 64'(busy_a), 64'd0);
         if (stall_a) begin
            check_eq("stall_valid", 64'(bus_a.out_valid), 64'd1);
            check_eq("stall_data", 64'(bus_a.slide_data), 64'(stall_data_a));
            check_eq("stall_idx", 64'(bus_a.win_idx), 64'(stall_idx_a));
            check_eq("stall_last", 64'(bus_a.out_last), 64'(stall_last_a));
         end
         if (done_a) begin
            check_eq("done_after_last", 64'(cyc - last_hs_cyc_a), 64'd1);
            exp_k_a = 0;
         end
         done_seen_a = done_a;
         if (bus_a.out_valid && bus_a.out_ready) begin
            check_eq("win_idx", 64'(bus_a.win_idx), 64'(exp_k_a));
            check_eq("win_data", 64'(bus_a.slide_data), 64'(model_win(1'b0, exp_k_a)));
            check_eq("win_last", 64'(bus_a.out_last), 64'(exp_k_a == A_NWIN - 1));
            if (exp_k_a == A_NWIN - 1) last_hs_cyc_a = cyc;
            hs_a++;
            exp_k_a++;
         end
         stall_a      = bus_a.out_valid && !bus_a.out_ready;
         stall_data_a = bus_a.slide_data;
         stall_idx_a  = bus_a.win_idx;
         stall_last_a = bus_a.out_last;
      end
   end

   // Stream monitor for the two-word record
   int exp_k_b = 0;
   int hs_b = 0;

   always @(negedge clk) begin
      if (rst || done_b) begin
         exp_k_b = 0;
      end else if (bus_b.out_valid && bus_b.out_ready) begin
         check_eq("b_win_idx", 64'(bus_b.win_idx), 64'(exp_k_b));
         check_eq("b_win_data", 64'(bus_b.slide_data), 64'(model_win(1'b1, exp_k_b)));
         check_eq("b_win_last", 64'(bus_b.out_last), 64'(exp_k_b == B_NWIN - 1));
         hs_b++;
         exp_k_b++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idx_a(input int target);
      int n = 0;
      while (!(bus_a.out_valid && bus_a.win_idx == 9'(target)) && n < 3000) begin
         tick();
         n++;
      end
      if (n >= 3000) check_eq("timeout_idx", 64'd0, 64'(target));
   endtask

   task automatic wait_done(input bit use_b);
      int n = 0;
      while (!(use_b ? done_b : done_a) && n < 5000) begin
         tick();
         n++;
      end
      if (n >= 5000) check_eq("timeout_done", 64'd0, 64'd1);
   endtask

   task automatic run_pass_a(input string tag);
      int hs0 = hs_a;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_done(1'b0);
      tick();
      check_eq(tag, 64'(hs_a - hs0), 64'(A_NWIN));
   endtask

   initial begin
      int c;
      int hs0;
      logic [31:0] w;

      bus_b.out_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rom_a[i] = 32'hA5A5A5A5;
         rom_b[i] = $urandom();
      end

      rst = 1'b1;
      repeat (3) tick();
      check_eq("rst_valid", 64'(bus_a.out_valid), 64'd0);
      check_eq("rst_busy", 64'(busy_a), 64'd0);
      check_eq("rst_done", 64'(done_a), 64'd0);
      check_eq("rst_rom_en", 64'(bus_a.rom_en), 64'd0);
      check_eq("rst_rom_addr", 64'(bus_a.rom_addr), 64'd0);
      check_eq("rst_data", 64'(bus_a.slide_data), 64'd0);
      check_eq("rst_idx", 64'(bus_a.win_idx), 64'd0);
      check_eq("rst_last", 64'(bus_a.out_last), 64'd0);
      check_eq("rst_b_busy", 64'(busy_b), 64'd0);
      rst = 1'b0;
      tick();

      // Constant-pattern record: latency, first windows, first word crossing
      hs0 = hs_a;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      c = 1;
      while (!bus_a.out_valid && c < 20) begin
         tick();
         c++;
      end
      check_eq("first_valid_cycle", 64'(c), 64'd4);
      check_eq("win0_data", 64'(bus_a.slide_data), 64'h52);
      check_eq("win0_idx", 64'(bus_a.win_idx), 64'd0);
      tick();
      check_eq("win1_data", 64'(bus_a.slide_data), 64'h4B);
      check_eq("win1_idx", 64'(bus_a.win_idx), 64'd1);
      wait_idx_a(15);
      tick();
      check_eq("bubble0_valid", 64'(bus_a.out_valid), 64'd0);
      tick();
      check_eq("bubble1_valid", 64'(bus_a.out_valid), 64'd0);
      tick();
      w = rom_a[1];
      check_eq("win16_valid", 64'(bus_a.out_valid), 64'd1);
      check_eq("win16_idx", 64'(bus_a.win_idx), 64'd16);
      check_eq("win16_data", 64'(bus_a.slide_data), 64'(w[31:25]));
      wait_done(1'b0);
      tick();
      check_eq("pass_a5_count", 64'(hs_a - hs0), 64'(A_NWIN));

      // Random record, always ready, then the same record under random backpressure
      for (int i = 0; i < 32; i++) rom_a[i] = $urandom();
      run_pass_a("pass_rand_count");
      check_eq("max_rom_addr_a", 64'(max_addr_a), 64'd28);
      rand_ready = 1'b1;
      run_pass_a("pass_stall_count");
      rand_ready = 1'b0;
      tick();

      // Ignored restart, reset abort, fresh pass
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_idx_a(100);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check_eq("restart_ignored_busy", 64'(busy_a), 64'd1);
      wait_idx_a(200);
      rst = 1'b1;
      tick();
      check_eq("abort_busy", 64'(busy_a), 64'd0);
      check_eq("abort_valid", 64'(bus_a.out_valid), 64'd0);
      check_eq("abort_idx", 64'(bus_a.win_idx), 64'd0);
      check_eq("abort_data", 64'(bus_a.slide_data), 64'd0);
      check_eq("abort_last", 64'(bus_a.out_last), 64'd0);
      check_eq("abort_rom_en", 64'(bus_a.rom_en), 64'd0);
      check_eq("abort_rom_addr", 64'(bus_a.rom_addr), 64'd0);
      check_eq("abort_done", 64'(done_a), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("post_abort_done", 64'(done_a | busy_a), 64'd0);
      end
      run_pass_a("pass_after_abort_count");

      // Two-word record, stride 3
      hs0 = hs_b;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      wait_done(1'b1);
      tick();
      check_eq("b_count", 64'(hs_b - hs0), 64'(B_NWIN));
      check_eq("b_max_rom_addr", 64'(max_addr_b), 64'd1);
      check_eq("b_busy_end", 64'(busy_b), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
